// File: rtl/ha_array_mul_seq.sv
// Sequencer/accumulator for the 8x8 approximate multiplier half-adder-array stage.
// Holds one operand pair on x_o/y_o and folds the four returned ha rows into a saturated product.
module ha_array_mul_seq #(
    parameter int NUM_ROWS    = 4,
    parameter int ROW_SHIFT   = 2,
    parameter int CARRY_SHIFT = 2,
    parameter int PW          = 16,
    parameter int AW          = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            x_in,
    input  logic [7:0]            y_in,
    output logic [7:0]            x_o,
    output logic [7:0]            y_o,
    input  logic [NUM_ROWS*7-1:0] ha_b,
    input  logic [NUM_ROWS*9-1:0] ha_t,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PW-1:0]         product,
    output logic                  ovf,
    output logic                  busy
);

    localparam int BW = 7;
    localparam int TW = 9;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [RW-1:0]   row;
    logic [AW-1:0]   acc;
    logic [TW-1:0]   t_sel;
    logic [BW-1:0]   b_sel;
    logic [AW-1:0]   row_val;
    logic [AW-1:0]   row_term;
    logic            last_row;

    function automatic logic [PW-1:0] sat_product(input logic [AW-1:0] a);
        if (|a[AW-1:PW])
            return '1;
        return a[PW-1:0];
    endfunction

    // Row r is weighted by 2^(ROW_SHIFT*r); its b vector sits CARRY_SHIFT above t.
    always_comb begin
        t_sel    = ha_t[int'(row)*TW +: TW];
        b_sel    = ha_b[int'(row)*BW +: BW];
        row_val  = AW'(t_sel) + (AW'(b_sel) << CARRY_SHIFT);
        row_term = row_val << (ROW_SHIFT * int'(row));
        last_row = (row == RW'(NUM_ROWS - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ACC;
            ACC:     if (last_row) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = sat_product(acc);
    assign ovf       = |acc[AW-1:PW];

    // acc is left untouched in DONE so product/ovf hold through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            x_o   <= '0;
            y_o   <= '0;
            acc   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_o <= x_in;
                        y_o <= y_in;
                        acc <= '0;
                        row <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + row_term;
                    if (!last_row)
                        row <= row + RW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ha_array_mul_seq.sv
// Directed and randomized bench for ha_array_mul_seq; the ha_array rows are modelled here
// from x_o/y_o (or forced from tables) and products come from a plain-arithmetic row sum.
module tb_ha_array_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [7:0]  x_o;
    logic [7:0]  y_o;
    logic [27:0] ha_b;
    logic [35:0] ha_t;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        ovf;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic       use_model;
    logic [8:0] dt[4];
    logic [6:0] db[4];

    ha_array_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .x_o       (x_o),
        .y_o       (y_o),
        .ha_b      (ha_b),
        .ha_t      (ha_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] row_t(input logic [7:0] x, input logic [7:0] y, input int r);
        int s;
        s = int'(x[2*r +: 2]);
        return 9'(s * int'(y));
    endfunction

    function automatic logic [6:0] row_b(input logic [7:0] x, input logic [7:0] y, input int r);
        logic [1:0] s;
        s = x[2*r +: 2];
        if (s == 2'b11) return y[7:1];
        if (s[0])       return y[6:0];
        return 7'h00;
    endfunction

    always_comb begin
        ha_t = '0;
        ha_b = '0;
        for (int r = 0; r < 4; r++) begin
            ha_t[9*r +: 9] = use_model ? row_t(x_o, y_o, r) : dt[r];
            ha_b[7*r +: 7] = use_model ? row_b(x_o, y_o, r) : db[r];
        end
    end

    // Full-precision row sum: sum over r of (t_r + 4*b_r) * 4^r.
    function automatic int ref_acc(input logic [7:0] x, input logic [7:0] y);
        int a;
        int t;
        int b;
        a = 0;
        for (int r = 0; r < 4; r++) begin
            t = use_model ? int'(row_t(x, y, r)) : int'(dt[r]);
            b = use_model ? int'(row_b(x, y, r)) : int'(db[r]);
            a += (t + 4 * b) * (1 << (2 * r));
        end
        return a;
    endfunction

    function automatic logic [15:0] ref_prod(input int a);
        logic [31:0] v;
        v = a;
        return (a > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rows(input logic [8:0] t, input logic [6:0] b);
        for (int r = 0; r < 4; r++) begin
            dt[r] = t;
            db[r] = b;
        end
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string tag);
        int a;
        a = ref_acc(x, y);
        in_valid = 1'b1;
        x_in = x;
        y_in = y;
        tick();
        in_valid = 1'b0;
        chk({tag, "_xo"}, 32'(x_o), 32'(x));
        chk({tag, "_yo"}, 32'(y_o), 32'(y));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (3) tick();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_prod"}, 32'(product), 32'(ref_prod(a)));
        chk({tag, "_ovf"}, 32'(ovf), (a > 65535) ? 32'd1 : 32'd0);
        tick();
        chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int          a;
        logic [7:0]  bx;
        logic [15:0] ep;
        logic        acc_now;
        logic        out_now;
        int          expq[$];
        int          last_acc;
        int          n_out;
        int          e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        y_in      = '0;
        use_model = 1'b0;
        set_rows(9'h000, 7'h00);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xo", 32'(x_o), 32'd0);
        chk("rst_yo", 32'(y_o), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        tick();

        run_op(8'h00, 8'h00, "zero");

        set_rows(9'h000, 7'h00);
        dt[2] = 9'h001;
        run_op(8'h12, 8'h34, "w_t2");
        chk("w_t2_const", 32'(product), 32'h0000_0010);

        set_rows(9'h000, 7'h00);
        db[1] = 7'h01;
        run_op(8'h56, 8'h78, "w_b1");

        set_rows(9'h1FF, 7'h7F);
        chk("sat_ref_acc", 32'(ref_acc(8'h00, 8'h00)), 32'd86615);
        run_op(8'hFF, 8'hFF, "sat");

        // Backpressure: hold the result for 10 cycles while extra in_valid is ignored.
        for (int r = 0; r < 4; r++) begin
            dt[r] = 9'($urandom);
            db[r] = 7'($urandom);
        end
        bx = 8'h5A;
        a = ref_acc(bx, 8'hC3);
        ep = ref_prod(a);
        out_ready = 1'b0;
        in_valid = 1'b1;
        x_in = bx;
        y_in = 8'hC3;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x_in = 8'($urandom);
            y_in = 8'($urandom);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_prod", 32'(product), 32'(ep));
            chk("bp_ovf", 32'(ovf), (a > 65535) ? 32'd1 : 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp_xo", 32'(x_o), 32'(bx));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset while the row counter sits at 2.
        set_rows(9'h1FF, 7'h7F);
        in_valid = 1'b1;
        x_in = 8'hA5;
        y_in = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_acc", 32'(product), 32'd0);
        use_model = 1'b1;
        run_op(8'($urandom), 8'($urandom), "post_rst");

        for (int i = 0; i < 4; i++)
            run_op(8'($urandom), 8'($urandom), "rand");
        run_op(8'hFF, 8'hFF, "model_ff");

        // Back-to-back with in_valid held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x_in = 8'($urandom);
        y_in = 8'($urandom);
        last_acc = -1;
        n_out = 0;
        for (int c = 0; c < 200 && n_out < 8; c++) begin
            acc_now = in_ready && in_valid;
            out_now = out_valid && out_ready;
            if (out_now) begin
                chk("b2b_queue", (expq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("b2b_prod", 32'(product), 32'(e[15:0]));
                    chk("b2b_ovf", 32'(ovf), 32'(e[16]));
                end
                n_out++;
            end
            if (acc_now) begin
                a = ref_acc(x_in, y_in);
                expq.push_back({15'd0, (a > 65535), ref_prod(a)});
                if (last_acc >= 0)
                    chk("b2b_spacing", 32'(c - last_acc), 32'd6);
                last_acc = c;
            end
            tick();
            if (acc_now) begin
                x_in = 8'($urandom);
                y_in = 8'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(n_out), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
